// File: rtl/ethernet_st_latency_source.sv
// ethernet_st_latency_source: bridges a readyLatency=0 Avalon-ST packet source onto a sink
// with readyLatency=READY_LATENCY, repairing packet framing and keeping packet/drop statistics.
`default_nettype none

module ethernet_st_latency_source #(
   parameter int DATA_W        = 32,
   parameter int EMPTY_W       = 2,
   parameter int READY_LATENCY = 2,
   parameter int CNT_W         = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               in_ready,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_startofpacket,
   input  logic               in_endofpacket,
   input  logic [EMPTY_W-1:0] in_empty,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [EMPTY_W-1:0] out_empty,
   output logic [CNT_W-1:0]   pkt_count,
   output logic [CNT_W-1:0]   drop_count,
   output logic               err_framing
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PKT  = 1'b1;

   logic               w_grant;
   logic               w_acc;
   logic               w_fwd;
   logic               w_sop;
   logic               w_eop;
   logic [EMPTY_W-1:0] w_empty;
   logic               w_err;
   logic               w_pkt_inc;
   logic               w_drop_inc;
   logic [0:0]         w_state_nxt;
   logic [0:0]         r_state;

   // The output register adds one cycle, so the grant only needs READY_LATENCY-1 stages.
   generate
      if (READY_LATENCY == 1) begin : g_rl_comb
         assign w_grant = out_ready;
      end else begin : g_rl_pipe
         logic [READY_LATENCY-2:0] r_rdy_pipe;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_rdy_pipe <= '0;
            end else begin
               r_rdy_pipe[0] <= out_ready;
               for (int i = 1; i < READY_LATENCY-1; i++) begin
                  r_rdy_pipe[i] <= r_rdy_pipe[i-1];
               end
            end
         end
         assign w_grant = r_rdy_pipe[READY_LATENCY-2];
      end
   endgenerate

   assign in_ready = w_grant;
   assign w_acc    = in_valid & w_grant;

   always_comb begin
      w_fwd       = 1'b0;
      w_sop       = in_startofpacket;
      w_eop       = in_endofpacket;
      w_empty     = in_empty;
      w_err       = 1'b0;
      w_pkt_inc   = 1'b0;
      w_drop_inc  = 1'b0;
      w_state_nxt = r_state;
      if (w_acc) begin
         if (r_state == S_IDLE) begin
            if (in_startofpacket) begin
               w_fwd = 1'b1;
               if (in_endofpacket) w_pkt_inc = 1'b1;
               else                w_state_nxt = S_PKT;
            end else begin
               w_drop_inc = 1'b1;
               w_err      = 1'b1;
            end
         end else begin
            w_fwd = 1'b1;
            if (in_startofpacket) begin
               // A new sop inside an open packet closes the old one with this beat.
               w_sop       = 1'b0;
               w_eop       = 1'b1;
               w_empty     = '0;
               w_err       = 1'b1;
               w_pkt_inc   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (in_endofpacket) begin
               w_pkt_inc   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
      end
      if (!w_eop) w_empty = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state           <= S_IDLE;
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_empty         <= '0;
         pkt_count         <= '0;
         drop_count        <= '0;
         err_framing       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         out_valid   <= w_fwd;
         err_framing <= w_err;
         if (w_fwd) begin
            out_data          <= in_data;
            out_startofpacket <= w_sop;
            out_endofpacket   <= w_eop;
            out_empty         <= w_empty;
         end
         if (w_pkt_inc && (pkt_count != {CNT_W{1'b1}}))
            pkt_count <= pkt_count + 1'b1;
         if (w_drop_inc && (drop_count != {CNT_W{1'b1}}))
            drop_count <= drop_count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ethernet_st_latency_source.sv
// Directed bench: one instance at READY_LATENCY=2 for framing/reset, one at 3 for grant timing.
`default_nettype none

module tb_ethernet_st_latency_source;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst2_n, in_valid2, in_sop2, in_eop2, out_ready2;
   logic [31:0] in_data2;
   logic [1:0]  in_empty2;
   logic        in_ready2, out_valid2, out_sop2, out_eop2, err2;
   logic [31:0] out_data2;
   logic [1:0]  out_empty2;
   logic [15:0] pkt2, drop2;

   logic        rst3_n, in_valid3, in_sop3, in_eop3, out_ready3;
   logic [31:0] in_data3;
   logic [1:0]  in_empty3;
   logic        in_ready3, out_valid3, out_sop3, out_eop3, err3;
   logic [31:0] out_data3;
   logic [1:0]  out_empty3;
   logic [15:0] pkt3, drop3;

   int total = 0;
   int bad   = 0;

   ethernet_st_latency_source #(.DATA_W(32), .EMPTY_W(2), .READY_LATENCY(2), .CNT_W(16)) u_dut2 (
      .clk(clk), .reset_n(rst2_n), .in_ready(in_ready2), .in_valid(in_valid2),
      .in_data(in_data2), .in_startofpacket(in_sop2), .in_endofpacket(in_eop2),
      .in_empty(in_empty2), .out_ready(out_ready2), .out_valid(out_valid2),
      .out_data(out_data2), .out_startofpacket(out_sop2), .out_endofpacket(out_eop2),
      .out_empty(out_empty2), .pkt_count(pkt2), .drop_count(drop2), .err_framing(err2)
   );

   ethernet_st_latency_source #(.DATA_W(32), .EMPTY_W(2), .READY_LATENCY(3), .CNT_W(16)) u_dut3 (
      .clk(clk), .reset_n(rst3_n), .in_ready(in_ready3), .in_valid(in_valid3),
      .in_data(in_data3), .in_startofpacket(in_sop3), .in_endofpacket(in_eop3),
      .in_empty(in_empty3), .out_ready(out_ready3), .out_valid(out_valid3),
      .out_data(out_data3), .out_startofpacket(out_sop3), .out_endofpacket(out_eop3),
      .out_empty(out_empty3), .pkt_count(pkt3), .drop_count(drop3), .err_framing(err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat2(input logic v, input logic [31:0] d, input logic s, input logic e,
                        input logic [1:0] em);
      in_valid2 = v; in_data2 = d; in_sop2 = s; in_eop2 = e; in_empty2 = em;
   endtask

   initial begin
      logic [0:8] pat;
      int k, j;
      logic exp_rdy, exp_ov;

      rst2_n = 1'b0; rst3_n = 1'b0;
      beat2(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      out_ready2 = 1'b1;
      in_valid3 = 1'b0; in_data3 = 32'h0; in_sop3 = 1'b0; in_eop3 = 1'b0; in_empty3 = 2'd0;
      out_ready3 = 1'b0;
      tick(); tick();

      // reset state
      chk("rst_out_valid", out_valid2, 0);
      chk("rst_out_data", out_data2, 0);
      chk("rst_pkt", pkt2, 0);
      chk("rst_drop", drop2, 0);
      chk("rst_in_ready_pipe", in_ready2, 0);
      chk("rst_err", err2, 0);

      rst2_n = 1'b1; rst3_n = 1'b1;
      chk("rel_in_ready", in_ready2, 0);
      tick();
      chk("grant_in_ready", in_ready2, 1);

      // 4-beat packet, out_ready held high
      beat2(1'b1, 32'h11111111, 1'b1, 1'b0, 2'd0);
      tick();
      chk("p1_valid", out_valid2, 1);
      chk("p1_data", out_data2, 32'h11111111);
      chk("p1_sop", out_sop2, 1);
      chk("p1_eop", out_eop2, 0);
      beat2(1'b1, 32'h22222222, 1'b0, 1'b0, 2'd3);
      tick();
      chk("p2_valid", out_valid2, 1);
      chk("p2_data", out_data2, 32'h22222222);
      chk("p2_sop", out_sop2, 0);
      chk("p2_empty_forced", out_empty2, 0);
      beat2(1'b1, 32'h33333333, 1'b0, 1'b0, 2'd0);
      tick();
      chk("p3_valid", out_valid2, 1);
      chk("p3_data", out_data2, 32'h33333333);
      beat2(1'b1, 32'h44444444, 1'b0, 1'b1, 2'd2);
      tick();
      chk("p4_valid", out_valid2, 1);
      chk("p4_data", out_data2, 32'h44444444);
      chk("p4_eop", out_eop2, 1);
      chk("p4_empty", out_empty2, 2);
      chk("p4_pkt", pkt2, 1);
      beat2(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      tick();
      chk("idle_valid", out_valid2, 0);
      chk("idle_hold_data", out_data2, 32'h44444444);
      chk("idle_hold_eop", out_eop2, 1);

      // non-sop beat while IDLE is dropped
      beat2(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'd0);
      tick();
      chk("drop_valid", out_valid2, 0);
      chk("drop_count", drop2, 1);
      chk("drop_err", err2, 1);
      chk("drop_hold_data", out_data2, 32'h44444444);
      beat2(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
      tick();
      chk("drop_err_pulse", err2, 0);

      // sop inside open packet at beat 3
      beat2(1'b1, 32'hA1A1A1A1, 1'b1, 1'b0, 2'd0);
      tick();
      chk("s1_sop", out_sop2, 1);
      beat2(1'b1, 32'hA2A2A2A2, 1'b0, 1'b0, 2'd0);
      tick();
      chk("s2_data", out_data2, 32'hA2A2A2A2);
      beat2(1'b1, 32'hA3A3A3A3, 1'b1, 1'b0, 2'd3);
      tick();
      chk("s3_valid", out_valid2, 1);
      chk("s3_data", out_data2, 32'hA3A3A3A3);
      chk("s3_sop", out_sop2, 0);
      chk("s3_eop", out_eop2, 1);
      chk("s3_empty", out_empty2, 0);
      chk("s3_pkt", pkt2, 2);
      chk("s3_err", err2, 1);
      beat2(1'b1, 32'hA4A4A4A4, 1'b0, 1'b0, 2'd0);
      tick();
      chk("s4_valid", out_valid2, 0);
      chk("s4_drop", drop2, 2);
      beat2(1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 2'd1);
      tick();
      chk("s5_valid", out_valid2, 0);
      chk("s5_drop", drop2, 3);
      chk("s5_pkt", pkt2, 2);

      // single-beat packet
      beat2(1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, 2'd3);
      tick();
      chk("sb_valid", out_valid2, 1);
      chk("sb_sop", out_sop2, 1);
      chk("sb_eop", out_eop2, 1);
      chk("sb_empty", out_empty2, 3);
      chk("sb_pkt", pkt2, 3);
      chk("sb_err", err2, 0);
      beat2(1'b1, 32'h66666666, 1'b0, 1'b1, 2'd0);
      tick();
      chk("sb_idle_drop_valid", out_valid2, 0);
      chk("sb_idle_drop", drop2, 4);

      // reset mid-packet
      beat2(1'b1, 32'hB1B1B1B1, 1'b1, 1'b0, 2'd0);
      tick();
      chk("mr_valid_before", out_valid2, 1);
      rst2_n = 1'b0;
      #1;
      chk("mr_valid_async", out_valid2, 0);
      chk("mr_pkt", pkt2, 0);
      chk("mr_drop", drop2, 0);
      chk("mr_in_ready", in_ready2, 0);
      tick();
      rst2_n = 1'b1;
      beat2(1'b1, 32'hB2B2B2B2, 1'b0, 1'b0, 2'd0);
      chk("mr_rel_in_ready", in_ready2, 0);
      tick();
      chk("mr_refill_valid", out_valid2, 0);
      chk("mr_refill_in_ready", in_ready2, 1);
      chk("mr_refill_drop", drop2, 0);
      tick();
      chk("mr_post_valid", out_valid2, 0);
      chk("mr_post_drop", drop2, 1);
      chk("mr_post_err", err2, 1);
      beat2(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);

      // READY_LATENCY=3 grant timing with out_ready pattern 1,0,1,1,0
      pat = 9'b101100000;
      k = 0;
      j = 0;
      for (int c = 0; c < 9; c++) begin
         out_ready3 = pat[c];
         in_valid3  = (k < 3);
         in_data3   = 32'hC0000000 + k;
         in_sop3    = (k == 0);
         in_eop3    = (k == 2);
         exp_rdy = (c >= 2) ? pat[c-2] : 1'b0;
         exp_ov  = (c >= 3) ? pat[c-3] : 1'b0;
         chk($sformatf("rl3_in_ready_c%0d", c), in_ready3, exp_rdy);
         chk($sformatf("rl3_out_valid_c%0d", c), out_valid3, exp_ov);
         if (exp_ov) chk($sformatf("rl3_out_data_c%0d", c), out_data3, 32'hC0000000 + j);
         tick();
         if (exp_rdy && k < 3) k++;
         if (exp_ov) j++;
      end
      chk("rl3_pkt", pkt3, 1);
      chk("rl3_drop", drop3, 0);
      chk("rl3_last_eop", out_eop3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
